// File: rtl/mdio_master.sv
// Clause-22 MDIO management master: divides clk down to MDC and shifts out
// one 64-bit read or write frame per accepted request.
module mdio_master #(
  parameter int CLK_DIV = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_phy,
  input  logic [4:0]  req_reg,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        eth_mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_START,
    S_OPCODE,
    S_PHY_ADDR,
    S_REG_ADDR,
    S_TA,
    S_DATA
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_div;
  logic            r_mdc;
  logic [5:0]      r_bit;
  logic [63:0]     r_frame;
  logic            r_write;
  logic            r_mdio_o;
  logic            r_mdio_oe;
  logic [15:0]     r_shift;
  logic [15:0]     r_rdata;
  logic            r_ta_err;
  logic            r_err;
  logic            r_rsp_valid;

  logic            w_accept;
  logic            w_tick;
  logic            w_rise;
  logic            w_fall;
  logic            w_last;
  logic [5:0]      w_nxt_idx;
  logic [63:0]     w_frame;

  // Ready is withheld during the response cycle so back-to-back accepts
  // land one cycle after rsp_valid.
  assign req_ready = (r_state == S_IDLE) && !r_rsp_valid;
  assign busy      = (r_state != S_IDLE);
  assign w_accept  = req_valid && req_ready;

  assign w_tick    = (r_div == DIV_MAX);
  assign w_rise    = busy && w_tick && !r_mdc;
  assign w_fall    = busy && w_tick && r_mdc;
  assign w_last    = w_fall && (r_bit == 6'd63);
  assign w_nxt_idx = 6'd62 - r_bit;

  // Frame bit n lives at index 63-n; read frames carry 1s where the PHY drives.
  assign w_frame = {32'hFFFF_FFFF, 2'b01,
                    req_write ? 2'b01 : 2'b10,
                    req_phy, req_reg,
                    req_write ? 2'b10 : 2'b11,
                    req_write ? req_wdata : 16'hFFFF};

  assign eth_mdc   = r_mdc;
  assign mdio_o    = r_mdio_o;
  assign mdio_oe   = r_mdio_oe;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state: field boundaries are crossed on the MDC falling edge that ends
  // the last bit of each field.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_accept)                    w_state_nxt = S_PREAMBLE;
      S_PREAMBLE: if (w_fall && r_bit == 6'd31)    w_state_nxt = S_START;
      S_START:    if (w_fall && r_bit == 6'd33)    w_state_nxt = S_OPCODE;
      S_OPCODE:   if (w_fall && r_bit == 6'd35)    w_state_nxt = S_PHY_ADDR;
      S_PHY_ADDR: if (w_fall && r_bit == 6'd40)    w_state_nxt = S_REG_ADDR;
      S_REG_ADDR: if (w_fall && r_bit == 6'd45)    w_state_nxt = S_TA;
      S_TA:       if (w_fall && r_bit == 6'd47)    w_state_nxt = S_DATA;
      S_DATA:     if (w_last)                      w_state_nxt = S_IDLE;
      default:                                     w_state_nxt = S_IDLE;
    endcase
  end

  // Divider, MDC, serializer, read capture and response registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div       <= '0;
      r_mdc       <= 1'b0;
      r_bit       <= '0;
      r_frame     <= '0;
      r_write     <= 1'b0;
      r_mdio_o    <= 1'b1;
      r_mdio_oe   <= 1'b0;
      r_shift     <= '0;
      r_rdata     <= '0;
      r_ta_err    <= 1'b0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_accept) begin
        r_frame   <= w_frame;
        r_write   <= req_write;
        r_bit     <= '0;
        r_div     <= '0;
        r_mdc     <= 1'b0;
        r_mdio_o  <= w_frame[63];
        r_mdio_oe <= 1'b1;
        r_ta_err  <= 1'b0;
      end else if (busy) begin
        r_div <= w_tick ? '0 : r_div + 1'b1;
        if (w_tick) r_mdc <= ~r_mdc;
        if (w_rise) begin
          if (r_state == S_TA && r_bit[0]) r_ta_err <= mdio_i;
          if (r_state == S_DATA)           r_shift  <= {r_shift[14:0], mdio_i};
        end
        if (w_last) begin
          r_mdio_o    <= 1'b1;
          r_mdio_oe   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_err       <= !r_write && r_ta_err;
          if (!r_write) r_rdata <= r_shift;
        end else if (w_fall) begin
          r_bit     <= r_bit + 1'b1;
          r_mdio_o  <= r_frame[w_nxt_idx];
          // Reads release the line from the first turnaround bit onward.
          r_mdio_oe <= r_write || (r_bit < 6'd45);
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: frame shape, PHY read data, turnaround
// error, back-to-back accepts and mid-frame reset.
module tb_mdio_master;

  localparam int D  = 10;
  localparam int NC = 128 * D;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_phy;
  logic [4:0]  req_reg;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        eth_mdc;
  logic        mdio_o;
  logic        mdio_oe;
  logic        mdio_i;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_rdata = 16'h0000;

  mdio_master #(.CLK_DIV(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_phy   (req_phy),
    .req_reg   (req_reg),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .eth_mdc   (eth_mdc),
    .mdio_o    (mdio_o),
    .mdio_oe   (mdio_oe),
    .mdio_i    (mdio_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts in the accept cycle T; returns in cycle T+1+128*D (or at abort_c).
  task automatic run_frame(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                           input logic [15:0] wd, input logic [15:0] prd, input logic ta,
                           input logic hold, input int abort_c, input string nm);
    logic [63:0] exp_f;
    logic [63:0] cap;
    logic [15:0] last_rdata;
    logic        last_err;
    logic        oe_exp;
    int e_mdc, e_oe, e_o, e_rv, e_rdy, e_busy;
    int p, n;
    exp_f = {32'hFFFF_FFFF, 2'b01, wr ? 2'b01 : 2'b10, phy, rg,
             wr ? 2'b10 : 2'b00, wr ? wd : 16'h0000};
    cap = '0;
    last_rdata = '0;
    last_err = 1'b0;
    e_mdc = 0; e_oe = 0; e_o = 0; e_rv = 0; e_rdy = 0; e_busy = 0;
    chk({nm, "_ready_at_accept"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = wr;
    req_phy   = phy;
    req_reg   = rg;
    req_wdata = wd;
    for (int c = 1; c <= NC + 1; c++) begin
      tick();
      if (c == 1) begin
        if (!hold) req_valid = 1'b0;
        req_write = ~wr;
        req_phy   = ~phy;
        req_reg   = ~rg;
        req_wdata = ~wd;
      end
      p = (c - 1) % (2 * D);
      n = (c - 1) / (2 * D);
      if (c <= NC) begin
        oe_exp = wr || (n <= 45);
        if (eth_mdc !== (p >= D)) e_mdc++;
        if (mdio_oe !== oe_exp) e_oe++;
        if (oe_exp && mdio_o !== exp_f[63-n]) e_o++;
        if (busy !== 1'b1) e_busy++;
        if (rsp_valid !== 1'b0) e_rv++;
        if (p == D) cap[63-n] = mdio_o;
        if (p == 0) mdio_i = (n == 47) ? ta : ((n >= 48) ? prd[63-n] : 1'b1);
      end else begin
        chk({nm, "_rsp_valid"}, rsp_valid, 1'b1);
        chk({nm, "_end_oe"}, mdio_oe, 1'b0);
        chk({nm, "_end_mdio_o"}, mdio_o, 1'b1);
        chk({nm, "_end_mdc"}, eth_mdc, 1'b0);
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
        mdio_i = 1'b1;
      end
      if (req_ready !== 1'b0) e_rdy++;
      if (abort_c == c) return;
    end
    chk({nm, "_mdc_errs"}, e_mdc, 0);
    chk({nm, "_oe_errs"}, e_oe, 0);
    chk({nm, "_mdio_o_errs"}, e_o, 0);
    chk({nm, "_busy_errs"}, e_busy, 0);
    chk({nm, "_early_rsp"}, e_rv, 0);
    chk({nm, "_ready_while_busy"}, e_rdy, 0);
    if (wr) chk({nm, "_frame"}, cap, exp_f);
    else    chk({nm, "_frame_hdr"}, cap[63:18], exp_f[63:18]);
    if (!wr) exp_rdata = prd;
    chk({nm, "_rdata"}, last_rdata, exp_rdata);
    chk({nm, "_err"}, last_err, wr ? 1'b0 : ta);
  endtask

  initial begin
    int toggles;
    int rvs;
    logic last_mdc;
    rst = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_phy = '0;
    req_reg = '0;
    req_wdata = '0;
    mdio_i = 1'b1;

    // Reset state.
    repeat (5) tick();
    chk("rst_mdc", eth_mdc, 1'b0);
    chk("rst_mdio_o", mdio_o, 1'b1);
    chk("rst_mdio_oe", mdio_oe, 1'b0);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rdata", rsp_rdata, 16'h0000);
    chk("rst_err", rsp_err, 1'b0);

    // Idle after reset release: no MDC activity.
    rst = 1'b1;
    tick();
    chk("idle_ready", req_ready, 1'b1);
    toggles = 0;
    last_mdc = eth_mdc;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (eth_mdc !== last_mdc || busy !== 1'b0) toggles++;
      last_mdc = eth_mdc;
    end
    chk("idle_mdc_quiet", toggles, 0);

    run_frame(1'b0, 5'd1, 5'd1, 16'h0000, 16'h7849, 1'b0, 1'b0, 0, "rd1");
    tick();
    chk("rd1_ready_after", req_ready, 1'b1);

    run_frame(1'b1, 5'd3, 5'd0, 16'h1200, 16'h0000, 1'b0, 1'b0, 0, "wr1");
    tick();

    run_frame(1'b0, 5'd2, 5'd5, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 0, "nophy");
    tick();

    // req_valid held high: next accept exactly one cycle after rsp_valid.
    run_frame(1'b0, 5'd1, 5'd2, 16'h0000, 16'h1234, 1'b0, 1'b1, 0, "hold1");
    tick();
    run_frame(1'b1, 5'd4, 5'd7, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 0, "hold2");
    tick();

    // Reset asserted in the high half of DATA bit 50 of a read.
    run_frame(1'b0, 5'd1, 5'd3, 16'h0000, 16'h5555, 1'b0, 1'b0, 1 + 2*D*50 + D + 2, "abort");
    rst = 1'b0;
    tick();
    chk("abort_oe", mdio_oe, 1'b0);
    chk("abort_mdc", eth_mdc, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rsp_valid", rsp_valid, 1'b0);
    chk("abort_mdio_o", mdio_o, 1'b1);
    chk("abort_rdata", rsp_rdata, 16'h0000);
    exp_rdata = 16'h0000;
    mdio_i = 1'b1;
    tick();
    rst = 1'b1;
    rvs = 0;
    toggles = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (rsp_valid !== 1'b0) rvs++;
      if (eth_mdc !== 1'b0) toggles++;
    end
    chk("abort_no_rsp", rvs, 0);
    chk("abort_idle_mdc", toggles, 0);

    run_frame(1'b0, 5'd1, 5'd1, 16'h0000, 16'hA5C3, 1'b0, 1'b0, 0, "rd2");
    tick();
    chk("final_ready", req_ready, 1'b1);
    chk("final_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
